// File: rtl/dec_out_arbiter.sv
// dec_out_arbiter: buffers the Caesar/Scytale/ZigZag decryptor channels in
// per-channel FIFOs and shares one registered output port between them.
//
// Ports:
//   clk_sys                  system clock
//   rst_n                    synchronous reset, active HIGH (high = reset)
//   data0_i..data2_i         characters from channel 0/1/2
//   valid0_i..valid2_i       per-channel character strobe
//   data_o, chan_o, valid_o  registered arbitrated character and its source
//   ready_i                  downstream accept (transfer on valid_o && ready_i)
//   ovf_o                    sticky per-channel overflow (bit n = channel n)
//   busy_o                   any FIFO non-empty or valid_o high
//
// Build option: DEC_ARB_FIXED_PRIO_EN selects fixed priority 0 > 1 > 2
// instead of round-robin arbitration.
module dec_out_arbiter #(
    parameter int SYS_DWIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic [SYS_DWIDTH-1:0] data0_i,
    input  logic [SYS_DWIDTH-1:0] data1_i,
    input  logic [SYS_DWIDTH-1:0] data2_i,
    input  logic                  valid0_i,
    input  logic                  valid1_i,
    input  logic                  valid2_i,
    output logic [SYS_DWIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic [1:0]            chan_o,
    input  logic                  ready_i,
    output logic [2:0]            ovf_o,
    output logic                  busy_o
);

    localparam int NCH = 3;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // Channel successor with 2 -> 0 wrap.
    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
    endfunction

    // ------------------------------------------------------------------
    // Input bundling
    // ------------------------------------------------------------------
    logic [SYS_DWIDTH-1:0] in_data [NCH];
    logic [NCH-1:0]        in_vld;

    assign in_data[0] = data0_i;
    assign in_data[1] = data1_i;
    assign in_data[2] = data2_i;
    assign in_vld     = {valid2_i, valid1_i, valid0_i};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SYS_DWIDTH-1:0] mem_q    [NCH][FIFO_DEPTH];
    logic [SYS_DWIDTH-1:0] mem_d    [NCH][FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q [NCH];
    logic [AW-1:0]         wr_ptr_d [NCH];
    logic [AW-1:0]         rd_ptr_q [NCH];
    logic [AW-1:0]         rd_ptr_d [NCH];
    logic [CW-1:0]         cnt_q    [NCH];
    logic [CW-1:0]         cnt_d    [NCH];

    logic [NCH-1:0]        ovf_q;
    logic [NCH-1:0]        ovf_d;
    logic [SYS_DWIDTH-1:0] data_q;
    logic [SYS_DWIDTH-1:0] data_d;
    logic [1:0]            chan_q;
    logic [1:0]            chan_d;
    logic                  valid_q;
    logic                  valid_d;

    // ------------------------------------------------------------------
    // Arbitration signals
    // ------------------------------------------------------------------
    logic [NCH-1:0] nonempty;
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic           load;
    logic           grant_vld;
    logic [1:0]     grant;
    logic [1:0]     search_start;
    logic [1:0]     cand;

`ifdef DEC_ARB_FIXED_PRIO_EN
    // Fixed priority: the search always begins at channel 0.
    assign search_start = 2'd0;
`else
    logic [1:0] last_grant_q;
    logic [1:0] last_grant_d;

    assign search_start = next_ch(last_grant_q);

    always_comb begin
        last_grant_d = last_grant_q;
        if (load && grant_vld) begin
            last_grant_d = grant;
        end
    end

    // Reset to 2 so channel 0 is searched first.
    always_ff @(posedge clk_sys) begin
        if (rst_n) begin
            last_grant_q <= 2'd2;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            nonempty[n] = (cnt_q[n] != '0);
        end
    end

    // The output register may take a new byte when empty or being drained.
    always_comb begin
        load      = !valid_q || ready_i;
        grant_vld = 1'b0;
        grant     = 2'd0;
        cand      = search_start;
        for (int i = 0; i < NCH; i++) begin
            if (!grant_vld && nonempty[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
            cand = next_ch(cand);
        end
        pop = '0;
        if (load && grant_vld) begin
            pop[grant] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO update: a full FIFO still accepts when it is popped this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        mem_d = mem_q;
        ovf_d = ovf_q;
        push  = '0;
        for (int n = 0; n < NCH; n++) begin
            wr_ptr_d[n] = wr_ptr_q[n];
            rd_ptr_d[n] = rd_ptr_q[n];
            cnt_d[n]    = cnt_q[n];
            push[n]     = in_vld[n] && ((cnt_q[n] != FULL_CNT) || pop[n]);
            if (in_vld[n] && !push[n]) begin
                ovf_d[n] = 1'b1;
            end
            if (push[n]) begin
                mem_d[n][wr_ptr_q[n]] = in_data[n];
                wr_ptr_d[n]           = wr_ptr_q[n] + AW'(1);
            end
            if (pop[n]) begin
                rd_ptr_d[n] = rd_ptr_q[n] + AW'(1);
            end
            unique case ({push[n], pop[n]})
                2'b10:   cnt_d[n] = cnt_q[n] + CW'(1);
                2'b01:   cnt_d[n] = cnt_q[n] - CW'(1);
                default: cnt_d[n] = cnt_q[n];
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register: holds while stalled; on an idle load only valid drops.
    // ------------------------------------------------------------------
    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        if (load) begin
            if (grant_vld) begin
                data_d  = mem_q[grant][rd_ptr_q[grant]];
                chan_d  = grant;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_n) begin
            for (int n = 0; n < NCH; n++) begin
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
                cnt_q[n]    <= '0;
            end
            ovf_q   <= '0;
            data_q  <= '0;
            chan_q  <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            for (int n = 0; n < NCH; n++) begin
                wr_ptr_q[n] <= wr_ptr_d[n];
                rd_ptr_q[n] <= rd_ptr_d[n];
                cnt_q[n]    <= cnt_d[n];
            end
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
        end
    end

    // Storage needs no reset: the counts gate every read.
    always_ff @(posedge clk_sys) begin
        mem_q <= mem_d;
    end

    assign data_o  = data_q;
    assign chan_o  = chan_q;
    assign valid_o = valid_q;
    assign ovf_o   = ovf_q;
    assign busy_o  = valid_q | (|nonempty);

endmodule

// File: tb/tb_dec_out_arbiter.sv
// tb_dec_out_arbiter: scoreboard bench for dec_out_arbiter with a
// queue-based reference model, directed scenarios and random traffic.
module tb_dec_out_arbiter;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk_sys = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data0_i, data1_i, data2_i;
    logic          valid0_i, valid1_i, valid2_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic [1:0]    chan_o;
    logic          ready_i;
    logic [2:0]    ovf_o;
    logic          busy_o;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_sys = ~clk_sys;

    dec_out_arbiter #(.SYS_DWIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .data0_i  (data0_i),
        .data1_i  (data1_i),
        .data2_i  (data2_i),
        .valid0_i (valid0_i),
        .valid1_i (valid1_i),
        .valid2_i (valid2_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .chan_o   (chan_o),
        .ready_i  (ready_i),
        .ovf_o    (ovf_o),
        .busy_o   (busy_o)
    );

    // Reference model: one queue per channel plus a one-entry output slot.
    logic [DW-1:0] mq [3][$];
    logic [9:0]    sb [$];
    logic [DW-1:0] m_data;
    logic [1:0]    m_chan;
    logic          m_valid;
    logic [2:0]    m_ovf;
    int            m_lg;
    int            m_start, m_c, m_found;
    logic [2:0]    m_v;
    logic [DW-1:0] m_d [3];

    initial begin : model
        m_data = '0; m_chan = '0; m_valid = 1'b0; m_ovf = '0; m_lg = 2;
        forever begin
            @(posedge clk_sys);
            if (rst_n) begin
                for (int n = 0; n < 3; n++) mq[n].delete();
                sb.delete();
                m_data = '0; m_chan = '0; m_valid = 1'b0; m_ovf = '0; m_lg = 2;
            end else begin
                m_v = {valid2_i, valid1_i, valid0_i};
                m_d[0] = data0_i; m_d[1] = data1_i; m_d[2] = data2_i;
                if (!m_valid || ready_i) begin
                    m_found = 0;
`ifdef DEC_ARB_FIXED_PRIO_EN
                    m_start = 0;
`else
                    m_start = (m_lg + 1) % 3;
`endif
                    for (int i = 0; i < 3; i++) begin
                        m_c = (m_start + i) % 3;
                        if (m_found == 0 && mq[m_c].size() > 0) begin
                            m_found = 1;
                            m_data  = mq[m_c].pop_front();
                            m_chan  = 2'(m_c);
                            m_lg    = m_c;
                            sb.push_back({m_chan, m_data});
                        end
                    end
                    m_valid = (m_found != 0);
                end
                // Pop before push: a full queue accepts when drained this cycle.
                for (int n = 0; n < 3; n++) begin
                    if (m_v[n]) begin
                        if (mq[n].size() < DEPTH) mq[n].push_back(m_d[n]);
                        else m_ovf[n] = 1'b1;
                    end
                end
            end
        end
    end

    function automatic void chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int m_busy();
        return (m_valid || mq[0].size() > 0 || mq[1].size() > 0 || mq[2].size() > 0) ? 1 : 0;
    endfunction

    // Monitor: mid-cycle sampling; pops the scoreboard on each handshake.
    logic [9:0] exp_xfer;
    initial begin : monitor
        forever begin
            @(negedge clk_sys);
            chk("valid_o", int'(valid_o), int'(m_valid));
            chk("data_o", int'(data_o), int'(m_data));
            chk("chan_o", int'(chan_o), int'(m_chan));
            chk("ovf_o", int'(ovf_o), int'(m_ovf));
            chk("busy_o", int'(busy_o), m_busy());
            if (valid_o && ready_i && !rst_n) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_empty: got data %0h chan %0d expected no transfer",
                             data_o, chan_o);
                end else begin
                    exp_xfer = sb.pop_front();
                    chk("xfer_data", int'(data_o), int'(exp_xfer[7:0]));
                    chk("xfer_chan", int'(chan_o), int'(exp_xfer[9:8]));
                end
            end
        end
    end

    task automatic drive(input logic rst, input logic [2:0] v,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic rdy);
        rst_n    = rst;
        valid0_i = v[0]; valid1_i = v[1]; valid2_i = v[2];
        data0_i  = d0;   data1_i  = d1;   data2_i  = d2;
        ready_i  = rdy;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) drive(1'b0, 3'b000, 8'h00, 8'h00, 8'h00, rdy);
    endtask

    int rdy_pct;

    initial begin : stim
        // Reset with toggling strobes
        drive(1'b1, 3'b101, 8'hA5, 8'h5A, 8'h3C, 1'b1);
        drive(1'b1, 3'b010, 8'hC3, 8'h77, 8'h88, 1'b0);
        idle(2, 1'b1);

        // Single byte on channel 1
        drive(1'b0, 3'b010, 8'h00, 8'h41, 8'h00, 1'b1);
        idle(5, 1'b1);

        // Round-robin ordering
        drive(1'b1, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
        drive(1'b0, 3'b111, 8'h10, 8'h20, 8'h30, 1'b1);
        drive(1'b0, 3'b101, 8'h11, 8'h00, 8'h31, 1'b1);
        idle(8, 1'b1);

        // Backpressure and overflow, then full FIFO with simultaneous read
        drive(1'b1, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
        for (int i = 1; i <= 6; i++) drive(1'b0, 3'b001, 8'(i), 8'h00, 8'h00, 1'b0);
        idle(3, 1'b0);
        drive(1'b0, 3'b001, 8'h07, 8'h00, 8'h00, 1'b1);
        idle(10, 1'b1);

        // Reset with channel 2 loaded and output valid
        drive(1'b1, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 3'b100, 8'h00, 8'h00, 8'(8'hE0 + i), 1'b0);
        idle(2, 1'b0);
        drive(1'b1, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
        drive(1'b0, 3'b100, 8'h00, 8'h00, 8'h55, 1'b1);
        idle(5, 1'b1);

        // Random traffic with varying backpressure and occasional resets
        for (int seg = 0; seg < 6; seg++) begin
            rdy_pct = (seg % 3 == 0) ? 100 : ((seg % 3 == 1) ? 60 : 25);
            for (int i = 0; i < 400; i++) begin
                drive(($urandom_range(0, 299) == 0),
                      3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)),
                      8'($urandom), 8'($urandom), 8'($urandom),
                      ($urandom_range(1, 100) <= rdy_pct));
            end
        end

        // Drain and confirm every expected transfer was seen
        idle(30, 1'b1);
        @(negedge clk_sys);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dec_out_arbiter.md
# dec_out_arbiter

Output arbiter on the system clock domain of the decryption datapath. It collects the decrypted characters produced by the Caesar, Scytale and ZigZag decryptor channels, which are fed by the demux outputs 0/1/2. It buffers each channel in a small FIFO and shares one 8-bit output port between them using round-robin byte-level arbitration with ready/valid backpressure.

## Interface
- SYS_DWIDTH, 8, character width.
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, ≥ 2.

- clk_sys  in  1  system clock; the only clock.
- rst_n  in  1  synchronous, active-high reset (high = reset); sampled on clk_sys.
- data0_i / data1_i / data2_i  in  SYS_DWIDTH  characters from the Caesar / Scytale / ZigZag decryptors.
- valid0_i / valid1_i / valid2_i  in  1  character strobe per channel; one character per cycle while high.
- data_o  out  SYS_DWIDTH  arbitrated character.
- valid_o  out  1  data_o/chan_o valid.
- chan_o  out  2  source channel of data_o (0, 1 or 2).
- ready_i  in  1  downstream accepts data_o when valid_o && ready_i.
- ovf_o  out  3  sticky per-channel overflow flag (bit n = channel n).
- busy_o  out  1  any FIFO non-empty or valid_o high.

## Operation
- Per channel: FIFO_DEPTH circular FIFO with write pointer, read pointer, and a $clog2(FIFO_DEPTH)+1 bit count. Pointers wrap modulo FIFO_DEPTH.
- Write: a validN_i cycle writes dataN_i if count < FIFO_DEPTH, or if the FIFO is full and read in the same cycle. Otherwise the byte is dropped and ovf_o[n] sets. ovf_o[n] stays set until reset.
- Output register (data_o, chan_o, valid_o) is loadable when valid_o == 0 or ready_i == 1.
- Arbitration when loadable:
  - Search the non-empty FIFOs starting at (last_grant+1) mod 3, wrapping 2→0.
  - Pop the first hit into the output register and set last_grant to that channel.
  - If no FIFO is non-empty, clear valid_o and leave data_o/chan_o unchanged.
- valid_o, data_o and chan_o hold stable while valid_o && !ready_i.
- No bypass: an input byte always passes through its FIFO.
- Reset:
  - All pointers and counts go to 0, and FIFO contents are discarded.
  - last_grant = 2, so channel 0 has first priority.
  - data_o = 0, chan_o = 0, valid_o = 0, ovf_o = 0, busy_o = 0.
  - Reset asserted mid-transfer drops everything in flight; there is no output on the reset cycle or the cycle after.

## Timing
- Latency: valid on input edge k gives valid_o at edge k+2 at the earliest (FIFO write at edge k+1, register load at edge k+2).
- Sustained throughput: 1 character/cycle total across all channels when ready_i is held high.
- Simultaneous writes on all three channels are all accepted in one cycle.
- Same-cycle write and read on one FIFO leaves the count unchanged.
- Fairness: with all three FIFOs continuously non-empty and ready_i high, the grant order is 0,1,2,0,1,2…
- Maximum storage per channel while stalled: FIFO_DEPTH in the FIFO plus 1 in the output register (shared across channels).

## Configuration
- DEC_ARB_FIXED_PRIO_EN defined: fixed priority, channel 0 > 1 > 2. The search always starts at channel 0, and last_grant is unused and not implemented.
- Not defined: round-robin as described in Operation.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold rst_n high 2 cycles with valid0_i..valid2_i toggling -> valid_o=0, data_o=0, chan_o=0, ovf_o=3'b000, busy_o=0 throughout.
- Single byte: ready_i=1, 0x41 on ch1 for one cycle at edge k -> valid_o=1, data_o=0x41, chan_o=1 for exactly one cycle at edge k+2; busy_o drops afterwards.
- Round-robin: ready_i=1, same cycle ch0=0x10, ch1=0x20, ch2=0x30, then ch0=0x11, ch2=0x31 -> outputs 0x10/0,0x20/1,0x30/2,0x11/0,0x31/2 on consecutive cycles. With DEC_ARB_FIXED_PRIO_EN: 0x10,0x11,0x20,0x30,0x31.
- Backpressure/overflow: ready_i=0, ch0 receives 0x01..0x06 on 6 consecutive cycles -> data_o=0x01 held stable, ovf_o=3'b001, 0x06 dropped. Then ready_i=1 -> 0x01..0x05 delivered on consecutive cycles and ovf_o remains 3'b001.
- Full FIFO with simultaneous read: ch0 full and ready_i=1 with a new byte 0x07 in the same cycle -> 0x07 accepted, ovf_o[0] unchanged.
- Reset mid-operation: ch2 holds 3 bytes, valid_o=1, then rst_n pulsed for 1 cycle -> all outputs 0 and no residual byte emitted. First post-reset byte 0x55 on ch2 appears 2 cycles after its write.
